serial_frame_ctrl: RTL and testbench

SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

---
 rtl/serial_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_serial_frame_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: sends one byte as a framed two-wire serial transfer
// (start condition, 8 data bits MSB first, stop condition). A frame is requested
// either through the tx_valid/tx_ready handshake or by pressing the
// bread-board button, which sends a fixed byte.
//
// Handshake: a transfer happens on a rising clk edge where tx_valid=1 and
// tx_ready=1; tx_data is captured on that edge. tx_ready is high only in IDLE.
// A requester does not have to hold tx_valid: a request made while busy is
// dropped, not queued. A button press counts only if it lands in IDLE, and
// tx_valid wins when both arrive in the same cycle.
module serial_frame_ctrl #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter logic [7:0]  BTN_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bbutton,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sda,
    output logic       sck,
    output logic       busy,
    output logic       done,
    output logic [2:0] fsm_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP_LO = 3'd3;
    localparam logic [2:0] STOP_HI = 3'd4;

    localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

    logic [2:0] state;
    logic [7:0] hp_cnt;
    logic       tick;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       phase_hi;
    logic       sync1;
    logic       sync2;
    logic       hist;
    logic       press;
    logic       accept;
    logic [7:0] payload;

    // Button synchroniser and history flop; idle level is 1 (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= bbutton;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Half-period timer: parked at 0 in IDLE, wraps after the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt <= 8'd0;
        end else if (state == IDLE || tick) begin
            hp_cnt <= 8'd0;
        end else begin
            hp_cnt <= hp_cnt + 8'd1;
        end
    end

    // Acceptance decision and payload selection for the IDLE state.
    always_comb begin
        tick    = (hp_cnt == HP_LAST);
        press   = hist & ~sync2;
        accept  = (state == IDLE) && (tx_valid || press);
        payload = tx_valid ? tx_data : BTN_BYTE;
    end

    // Frame sequencer; sda/sck are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= 8'd0;
            bit_cnt  <= 3'd0;
            phase_hi <= 1'b0;
            sda      <= 1'b1;
            sck      <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= payload;
                        bit_cnt  <= 3'd0;
                        phase_hi <= 1'b0;
                        state    <= START;
                        sda      <= 1'b0;
                        sck      <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state    <= DATA;
                        phase_hi <= 1'b0;
                        sda      <= shreg[7];
                        sck      <= 1'b0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (!phase_hi) begin
                            // Low phase over: raise sck, sda stays put.
                            phase_hi <= 1'b1;
                            sck      <= 1'b1;
                        end else begin
                            // High phase over: advance to the next bit.
                            shreg    <= {shreg[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                            phase_hi <= 1'b0;
                            sck      <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP_LO;
                                sda   <= 1'b0;
                            end else begin
                                sda   <= shreg[6];
                            end
                        end
                    end
                end
                STOP_LO: begin
                    if (tick) begin
                        state <= STOP_HI;
                        sck   <= 1'b1;
                        sda   <= 1'b0;
                    end
                end
                STOP_HI: begin
                    if (tick) begin
                        // sda rises while sck is high: stop condition.
                        state <= IDLE;
                        sck   <= 1'b1;
                        sda   <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    sda   <= 1'b1;
                    sck   <= 1'b1;
                end
            endcase
        end
    end

    // Status decode straight from the state register.
    always_comb begin
        tx_ready  = (state == IDLE);
        busy      = (state != IDLE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: a frame-level model predicts the expected
// {sda, sck, busy, tx_ready, done} for every cycle, a monitor decodes the
// bytes actually sent, and directed plus random stimulus drive the DUT.
module tb_serial_frame_ctrl;

    localparam int         HP  = 4;
    localparam logic [7:0] BTN = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       bbutton = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       sda;
    logic       sck;
    logic       busy;
    logic       done;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_ctrl #(.HALF_PERIOD(HP), .BTN_BYTE(BTN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bbutton   (bbutton),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .sda       (sda),
        .sck       (sck),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    // Expected output vector {sda, sck, busy, tx_ready, done}, one per cycle.
    logic [4:0] exp_q[$];
    logic [4:0] exp_now = 5'b11010;
    bit         m_idle  = 1'b1;
    logic       s1 = 1'b1, s2 = 1'b1, s3 = 1'b1;   // button samples of edges k-1, k-2, k-3
    bit         m_press;

    // A whole frame laid out as a waveform: start, 8 bits (low then high half), stop.
    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < HP; i++) exp_q.push_back(5'b01100);
        for (int k = 7; k >= 0; k--) begin
            for (int i = 0; i < HP; i++) exp_q.push_back({b[k], 4'b0100});
            for (int i = 0; i < HP; i++) exp_q.push_back({b[k], 4'b1100});
        end
        for (int i = 0; i < HP; i++) exp_q.push_back(5'b00100);
        for (int i = 0; i < HP; i++) exp_q.push_back(5'b01100);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_idle  = 1'b1;
                s1 = 1'b1; s2 = 1'b1; s3 = 1'b1;
                exp_now = 5'b11010;
            end else begin
                m_press = s3 && !s2;
                if (m_idle && (tx_valid || m_press))
                    push_frame(tx_valid ? tx_data : BTN);
                if (exp_q.size() > 0) begin
                    exp_now = exp_q.pop_front();
                    m_idle  = 1'b0;
                end else begin
                    exp_now = {4'b1101, !m_idle};
                    m_idle  = 1'b1;
                end
                s3 = s2; s2 = s1; s1 = bbutton;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("cycle_outputs", {27'd0, sda, sck, busy, tx_ready, done}, {27'd0, exp_now});
        end
    end

    // ---------------- frame monitor ----------------
    logic [7:0] got_q[$];
    int         lat_q[$];
    int         gap_q[$];
    logic       prev_sck = 1'b1, prev_busy = 1'b0;
    logic [7:0] shv = 8'h00;
    int         nbits = 0, cyc = 0, idle_run = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                gap_q.push_back(idle_run);
                nbits = 0; cyc = 0; shv = 8'h00;
            end else if (busy) begin
                cyc++;
            end
            if (!busy) idle_run++; else idle_run = 0;
            if (busy && sck && !prev_sck && nbits < 8) begin
                shv = {shv[6:0], sda};
                nbits++;
            end
            if (done) begin
                got_q.push_back(shv);
                lat_q.push_back(cyc + 1);
            end
            prev_sck  = sck;
            prev_busy = busy;
        end
    end

    task automatic clear_mon();
        got_q.delete();
        lat_q.delete();
        gap_q.delete();
    endtask

    task automatic wait_frames(input int n, input int max_cyc, input string name);
        int c = 0;
        while (got_q.size() < n && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        chk(name, got_q.size(), n);
    endtask

    // ---------------- driver / directed + random tests ----------------
    int dn;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("ready_in_reset", {31'd0, tx_ready}, 1);
        chk("sda_sck_in_reset", {30'd0, sda, sck}, 3);
        do_reset();

        // idle after reset
        clear_mon();
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("idle_lines", {28'd0, sda, sck, busy, tx_ready}, 32'b1101);
        chk("idle_no_done", dn, 0);

        // single tx_valid frame 8'h3C
        clear_mon();
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_frames(1, 200, "frame_3c_timeout");
        chk("frame_3c_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h3C);
        chk("frame_3c_latency", lat_q.size() > 0 ? lat_q[0] : -1, 19 * HP);

        // button held low for 10 cycles
        repeat (3) @(negedge clk);
        clear_mon();
        bbutton = 1'b0;
        @(negedge clk);
        chk("btn_edge1_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("btn_edge2_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("btn_edge3_busy", {31'd0, busy}, 1);
        repeat (7) @(negedge clk);
        bbutton = 1'b1;
        wait_frames(1, 200, "btn_timeout");
        repeat (100) @(negedge clk);
        chk("btn_frame_count", got_q.size(), 1);
        chk("btn_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'hA5);

        // tx_valid and press in the same cycle, then a press while busy
        clear_mon();
        bbutton = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data = 8'h81; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tie_busy", {31'd0, busy}, 1);
        repeat (2) @(negedge clk);
        bbutton = 1'b1;
        repeat (10) @(negedge clk);
        bbutton = 1'b0;
        repeat (10) @(negedge clk);
        bbutton = 1'b1;
        wait_frames(1, 200, "tie_timeout");
        repeat (100) @(negedge clk);
        chk("tie_frame_count", got_q.size(), 1);
        chk("tie_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h81);

        // reset during bit 4, then a clean 8'hFF frame
        clear_mon();
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (37) @(posedge clk);
        #1;
        chk("mid_frame_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_lines", {28'd0, sda, sck, busy, tx_ready}, 32'b1101);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("abandoned_no_done", got_q.size(), 0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_frames(1, 200, "after_rst_timeout");
        chk("after_rst_byte", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'hFF);
        chk("after_rst_latency", lat_q.size() > 0 ? lat_q[0] : -1, 19 * HP);

        // tx_valid held high: back-to-back frames
        repeat (3) @(negedge clk);
        clear_mon();
        tx_data = 8'h00; tx_valid = 1'b1;
        dn = 0;
        while (gap_q.size() < 2 && dn < 300) begin
            @(negedge clk);
            dn++;
        end
        tx_valid = 1'b0;
        chk("b2b_second_start", gap_q.size(), 2);
        wait_frames(2, 300, "b2b_timeout");
        repeat (100) @(negedge clk);
        chk("b2b_count", got_q.size(), 2);
        chk("b2b_byte0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h00);
        chk("b2b_byte1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h00);
        chk("b2b_gap", gap_q.size() > 1 ? gap_q[1] : -1, 1);

        // random traffic: requests, button activity and occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 39) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 29) == 0) bbutton = ~bbutton;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        bbutton  = 1'b1;
        rst_n    = 1'b1;
        repeat (200) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
